// File: rtl/pcie_cc_pkg.sv
// Shared completer-completion definitions.
//   CC_TUSER_DISCONTINUE / CC_TUSER_ECRC : bit positions inside CC tuser
//   cc_arb_state_e                       : arbiter lock state
package pcie_cc_pkg;

  localparam int CC_TUSER_DISCONTINUE = 3;
  localparam int CC_TUSER_ECRC        = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cc_arb_state_e;

endpackage

// File: rtl/s_axis_cc_arbiter_if.sv
// CC AXI-Stream bundle between the arbiter and the CC header adapter.
//   master : drives tdata/tkeep/tlast/tuser/tvalid, samples tready
//   slave  : the opposite direction
interface s_axis_cc_arbiter_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 4
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/s_axis_cc_arbiter_rr_pick.sv
// Combinational round-robin pick.
//   req    : request vector
//   last   : index granted most recently (lowest priority)
//   winner : first requesting index after last, wrapping at NUM_REQ
//   any    : at least one request present
module s_axis_cc_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  // One spare bit so last+k cannot overflow before the wrap compare.
  logic [IDX_W:0] idx;
  logic           found;

  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + (IDX_W+1)'(k);
      // Compare-and-subtract wrap keeps non-power-of-two NUM_REQ legal.
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      if (!found && req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-level round-robin arbiter sharing the CC stream between NUM_REQ
// completion sources. The grant is locked from first beat to tlast.
//   user_clk, user_reset_n : clock, async active-low reset
//   arb_hold               : block new grants (packet in flight finishes)
//   req_t*                 : flattened requester streams, slice i = requester i
//   s_axis_cc              : arbitrated stream towards the CC header adapter
//   grant_idx, busy        : status (current/last grant, packet locked)
module s_axis_cc_arbiter
  import pcie_cc_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           arb_hold,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]  req_tkeep,
  input  logic [NUM_REQ-1:0]             req_tlast,
  input  logic [NUM_REQ*USER_WIDTH-1:0]  req_tuser,
  input  logic [NUM_REQ-1:0]             req_tvalid,
  output logic [NUM_REQ-1:0]             req_tready,
  s_axis_cc_arbiter_if.master            s_axis_cc,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           busy
);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0][KEEP_WIDTH-1:0] req_keep;
  logic [NUM_REQ-1:0][USER_WIDTH-1:0] req_user;

  assign req_data = req_tdata;
  assign req_keep = req_tkeep;
  assign req_user = req_tuser;

  cc_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;

  s_axis_cc_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_tvalid),
    .last   (grant_q),
    .winner (winner),
    .any    (any_req)
  );

  // Reset grant to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q <= IDLE;
      grant_q <= IDX_W'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: if (!arb_hold && any_req) begin
        state_d = BUSY;
        grant_d = winner;
      end
      BUSY: if (s_axis_cc.tvalid && s_axis_cc.tready && s_axis_cc.tlast)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data always follows the current grant so nothing floats in IDLE;
  // only valid/ready are qualified by the lock.
  always_comb begin
    s_axis_cc.tdata  = req_data[grant_q];
    s_axis_cc.tkeep  = req_keep[grant_q];
    s_axis_cc.tlast  = req_tlast[grant_q];
    s_axis_cc.tuser  = req_user[grant_q];
    s_axis_cc.tvalid = (state_q == BUSY) && req_tvalid[grant_q];
    req_tready       = '0;
    if (state_q == BUSY) req_tready[grant_q] = s_axis_cc.tready;
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
module tb_s_axis_cc_arbiter;
  localparam int N  = 2;
  localparam int DW = 256;
  localparam int KW = DW/8;
  localparam int UW = 4;
  localparam int IW = 1;

  logic              user_clk = 1'b0;
  logic              user_reset_n = 1'b0;
  logic              arb_hold = 1'b0;
  logic [N*DW-1:0]   req_tdata;
  logic [N*KW-1:0]   req_tkeep;
  logic [N-1:0]      req_tlast;
  logic [N*UW-1:0]   req_tuser;
  logic [N-1:0]      req_tvalid;
  logic [N-1:0]      req_tready;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  s_axis_cc_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) cc_if ();

  s_axis_cc_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .arb_hold     (arb_hold),
    .req_tdata    (req_tdata),
    .req_tkeep    (req_tkeep),
    .req_tlast    (req_tlast),
    .req_tuser    (req_tuser),
    .req_tvalid   (req_tvalid),
    .req_tready   (req_tready),
    .s_axis_cc    (cc_if),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [15:0]   tag;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t srcq[N][$];
  bit    pause[N];
  int    cyc, n_chk, n_fail;
  bit    m_busy;
  int    m_grant;
  int    log_tag[$];
  int    log_cyc[$];

  function automatic logic [DW-1:0] mkdata(logic [15:0] t);
    return {16{t}};
  endfunction
  function automatic logic [KW-1:0] mkkeep(logic [15:0] t);
    return {2{~t}};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(string name, int i, int tag, int c);
    n_chk++;
    if (i >= log_tag.size()) begin
      n_fail++;
      $display("FAIL %s: beat %0d never accepted (expected tag %0h)", name, i, tag);
    end else if (log_tag[i] != tag || log_cyc[i] != c) begin
      n_fail++;
      $display("FAIL %s: beat %0d got tag %0h at cycle %0d expected tag %0h at cycle %0d",
               name, i, log_tag[i], log_cyc[i], tag, c);
    end
  endtask

  task automatic push_pkt(int r, int pkt, int nb, logic [UW-1:0] u);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.tag  = 16'(r*256 + pkt*16 + k);
      b.last = (k == nb-1);
      b.user = u;
      srcq[r].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !pause[i]) begin
        req_tvalid[i]          = 1'b1;
        req_tdata[i*DW +: DW]  = mkdata(srcq[i][0].tag);
        req_tkeep[i*KW +: KW]  = mkkeep(srcq[i][0].tag);
        req_tlast[i]           = srcq[i][0].last;
        req_tuser[i*UW +: UW]  = srcq[i][0].user;
      end else begin
        req_tvalid[i]          = 1'b0;
        req_tdata[i*DW +: DW]  = '0;
        req_tkeep[i*KW +: KW]  = '0;
        req_tlast[i]           = 1'b0;
        req_tuser[i*UW +: UW]  = '0;
      end
    end
  endtask

  // One clock: compare at negedge against the model, then advance model
  // and sources at posedge.
  task automatic cycle();
    bit        ev;
    bit [N-1:0] fire;
    beat_t     fb;
    drive();
    @(negedge user_clk);
    ev = m_busy && srcq[m_grant].size() > 0 && !pause[m_grant];
    chk("busy", 256'(busy), 256'(m_busy));
    chk("grant_idx", 256'(grant_idx), 256'(m_grant));
    chk("tvalid", 256'(cc_if.tvalid), 256'(ev));
    for (int i = 0; i < N; i++)
      chk("req_tready", 256'(req_tready[i]), 256'(m_busy && i == m_grant && cc_if.tready));
    if (ev) begin
      fb = srcq[m_grant][0];
      chk("tdata", cc_if.tdata, mkdata(fb.tag));
      chk("tkeep", 256'(cc_if.tkeep), 256'(mkkeep(fb.tag)));
      chk("tlast", 256'(cc_if.tlast), 256'(fb.last));
      chk("tuser", 256'(cc_if.tuser), 256'(fb.user));
    end
    for (int i = 0; i < N; i++) fire[i] = req_tvalid[i] & req_tready[i];
    if (cc_if.tvalid && cc_if.tready) begin
      log_tag.push_back(int'(cc_if.tdata[15:0]));
      log_cyc.push_back(cyc);
    end
    if (!m_busy) begin
      if (!arb_hold) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_grant + k) % N;
          if (srcq[c].size() > 0 && !pause[c]) begin
            m_grant = c;
            m_busy  = 1'b1;
            break;
          end
        end
      end
    end else if (ev && cc_if.tready && fb.last) begin
      m_busy = 1'b0;
    end
    @(posedge user_clk);
    cyc++;
    for (int i = 0; i < N; i++) if (fire[i]) void'(srcq[i].pop_front());
    #1;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic new_test(output int t0);
    log_tag.delete();
    log_cyc.delete();
    t0 = cyc;
  endtask

  int t0;
  bit pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    cc_if.tready = 1'b1;
    cyc = 0; n_chk = 0; n_fail = 0;
    drive();
    repeat (3) @(posedge user_clk);
    #1;
    chk("reset busy", 256'(busy), 256'(0));
    chk("reset tvalid", 256'(cc_if.tvalid), 256'(0));
    chk("reset req_tready", 256'(req_tready), 256'(0));
    chk("reset grant_idx", 256'(grant_idx), 256'(N-1));
    m_busy = 1'b0; m_grant = N-1;
    user_reset_n = 1'b1;

    // Both requesters, two 2-beat packets each: 0,1,0,1 with one bubble.
    new_test(t0);
    push_pkt(0, 0, 2, 4'b0000); push_pkt(0, 1, 2, 4'b0001);
    push_pkt(1, 0, 2, 4'b0000); push_pkt(1, 1, 2, 4'b1001);
    run(13);
    chk_log("rr b0", 0, 'h000, 1);  chk_log("rr b1", 1, 'h001, 2);
    chk_log("rr b2", 2, 'h100, 4);  chk_log("rr b3", 3, 'h101, 5);
    chk_log("rr b4", 4, 'h010, 7);  chk_log("rr b5", 5, 'h011, 8);
    chk_log("rr b6", 6, 'h110, 10); chk_log("rr b7", 7, 'h111, 11);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;

    // Requester 1 only, three single-beat packets.
    new_test(t0);
    push_pkt(1, 2, 1, 4'b0000); push_pkt(1, 3, 1, 4'b0000); push_pkt(1, 4, 1, 4'b0000);
    run(7);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;
    chk_log("single b0", 0, 'h120, 1);
    chk_log("single b1", 1, 'h130, 3);
    chk_log("single b2", 2, 'h140, 5);
    chk("single grant", 256'(grant_idx), 256'(1));

    // Backpressure on a 4-beat packet.
    new_test(t0);
    push_pkt(0, 5, 4, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      cc_if.tready = pat[k];
      cycle();
    end
    cc_if.tready = 1'b1;
    run(2);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;
    chk_log("bp b0", 0, 'h050, 1); chk_log("bp b1", 1, 'h051, 4);
    chk_log("bp b2", 2, 'h052, 5); chk_log("bp b3", 3, 'h053, 7);
    chk("bp count", 256'(log_tag.size()), 256'(4));

    // Granted source stalls mid-packet while requester 1 waits.
    new_test(t0);
    push_pkt(0, 6, 3, 4'b1000);
    run(2);
    push_pkt(1, 7, 1, 4'b0000);
    pause[0] = 1'b1;
    run(2);
    pause[0] = 1'b0;
    run(5);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;
    chk_log("stall b0", 0, 'h060, 1); chk_log("stall b1", 1, 'h061, 4);
    chk_log("stall b2", 2, 'h062, 5); chk_log("stall r1", 3, 'h170, 7);

    // arb_hold during a packet.
    new_test(t0);
    push_pkt(0, 8, 2, 4'b0000);
    run(1);
    arb_hold = 1'b1;
    push_pkt(1, 9, 1, 4'b0000);
    run(5);
    chk("hold idle busy", 256'(busy), 256'(0));
    arb_hold = 1'b0;
    run(3);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;
    chk_log("hold b0", 0, 'h080, 1); chk_log("hold b1", 1, 'h081, 2);
    chk_log("hold r1", 2, 'h190, 7);

    // Reset in the middle of a 4-beat packet.
    new_test(t0);
    push_pkt(0, 10, 4, 4'b0000);
    run(3);
    drive();
    #2;
    chk("pre-reset tvalid", 256'(cc_if.tvalid), 256'(1));
    user_reset_n = 1'b0;
    #1;
    chk("async reset tvalid", 256'(cc_if.tvalid), 256'(0));
    chk("async reset busy", 256'(busy), 256'(0));
    chk("async reset req_tready", 256'(req_tready), 256'(0));
    for (int i = 0; i < N; i++) srcq[i].delete();
    m_busy = 1'b0; m_grant = N-1;
    drive();
    repeat (2) @(posedge user_clk);
    #1;
    chk("reset grant_idx 2", 256'(grant_idx), 256'(N-1));
    user_reset_n = 1'b1;
    new_test(t0);
    push_pkt(1, 11, 1, 4'b0000);
    push_pkt(0, 12, 1, 4'b0000);
    run(5);
    foreach (log_cyc[i]) log_cyc[i] = log_cyc[i] - t0;
    chk_log("post-reset first", 0, 'h0c0, 1);
    chk_log("post-reset second", 1, 'h1b0, 3);

    for (int i = 0; i < N; i++) chk("drained", 256'(srcq[i].size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
